// File: rtl/tick_timer.sv
// Counts prescaler strobes and pulses expire after a programmable number of ticks.
// One-shot or auto-reload modes; sticky tick_err flags a strobe held high for two clocks or more.
module tick_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             expire,
  output logic             tick_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q,    state_d;
  logic [WIDTH-1:0] count_q,    count_d;
  logic [WIDTH-1:0] period_q,   period_d;
  logic             mode_q,     mode_d;
  logic             expire_q,   expire_d;
  logic             tick_err_q, tick_err_d;
  logic             tick_dly_q;
  logic             start_ok;

  // stop outranks start in both states, so a start that arrives with stop is not accepted
  assign start_ok = start && !stop && (period != '0);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    mode_d     = mode_q;
    expire_d   = 1'b0;
    tick_err_d = tick_err_q;

    if (stop) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (start) begin
      if (start_ok) begin
        state_d  = ST_RUN;
        count_d  = period;
        period_d = period;
        mode_d   = mode;
      end else begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    end else if ((state_q == ST_RUN) && tick) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        expire_d = 1'b1;
        if (mode_q) begin
          count_d = period_q;
        end else begin
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
    end

    // set takes precedence over the clear from an accepted start
    if (tick && tick_dly_q) begin
      tick_err_d = 1'b1;
    end else if (start_ok) begin
      tick_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      period_q   <= '0;
      mode_q     <= 1'b0;
      expire_q   <= 1'b0;
      tick_err_q <= 1'b0;
      tick_dly_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      mode_q     <= mode_d;
      expire_q   <= expire_d;
      tick_err_q <= tick_err_d;
      tick_dly_q <= tick;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign count    = count_q;
  assign expire   = expire_q;
  assign tick_err = tick_err_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer: one-shot, auto-reload, event collisions, tick_err and reset.
module tb_tick_timer;

  logic       clk = 1'b0;
  logic       reset, tick, start, stop, mode;
  logic [7:0] period;
  logic       busy, expire, tick_err;
  logic [7:0] count;

  int total = 0;
  int bad   = 0;
  int nexp;

  tick_timer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .mode(mode), .period(period), .busy(busy), .count(count),
    .expire(expire), .tick_err(tick_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock with tick driven to t; outputs are sampled 1ns after the edge
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] p, input logic m, input logic t);
    start = 1'b1; period = p; mode = m;
    cyc(t);
    start = 1'b0;
  endtask

  // n clocks with a tick on every 5th clock; counts expire pulses seen
  task automatic run_ticks(input int n, output int ne);
    ne = 0;
    for (int i = 0; i < n; i++) begin
      cyc(i % 5 == 4);
      if (expire) ne++;
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; period = '0;
    cyc(0); cyc(0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_expire", int'(expire), 0);
    chk("rst_err", int'(tick_err), 0);
    reset = 1'b0;

    // idle with ticks: nothing moves
    begin
      int nb = 0, nc = 0;
      nexp = 0;
      for (int i = 0; i < 100; i++) begin
        cyc(i % 5 == 4);
        if (busy) nb++;
        if (count != 0) nc++;
        if (expire) nexp++;
      end
      chk("idle_busy_cycles", nb, 0);
      chk("idle_count_cycles", nc, 0);
      chk("idle_expires", nexp, 0);
    end

    // one-shot, period 3
    pulse_start(8'd3, 1'b0, 1'b0);
    chk("os_load_count", int'(count), 3);
    chk("os_load_busy", int'(busy), 1);
    for (int k = 1; k <= 3; k++) begin
      nexp = 0;
      for (int j = 0; j < 4; j++) begin cyc(0); if (expire) nexp++; end
      chk("os_no_early_expire", nexp, 0);
      cyc(1);
      chk("os_count", int'(count), 3 - k);
      chk("os_expire", int'(expire), (k == 3) ? 1 : 0);
    end
    chk("os_busy_drop", int'(busy), 0);
    cyc(0);
    chk("os_expire_one_clk", int'(expire), 0);
    run_ticks(50, nexp);
    chk("os_no_more_expire", nexp, 0);

    // auto-reload, period 2, five periods
    pulse_start(8'd2, 1'b1, 1'b0);
    chk("ar_load_count", int'(count), 2);
    for (int p = 0; p < 5; p++) begin
      repeat (4) cyc(0);
      cyc(1);
      chk("ar_count_mid", int'(count), 1);
      chk("ar_expire_mid", int'(expire), 0);
      nexp = 0;
      for (int j = 0; j < 4; j++) begin cyc(0); if (expire) nexp++; end
      chk("ar_gap_quiet", nexp, 0);
      cyc(1);
      chk("ar_count_reload", int'(count), 2);
      chk("ar_expire", int'(expire), 1);
      chk("ar_busy", int'(busy), 1);
    end
    stop = 1'b1; cyc(0); stop = 1'b0;
    chk("ar_stop_busy", int'(busy), 0);
    chk("ar_stop_count", int'(count), 0);
    chk("ar_stop_expire", int'(expire), 0);
    run_ticks(20, nexp);
    chk("ar_stop_quiet", nexp, 0);

    // stop together with the terminal tick
    pulse_start(8'd1, 1'b0, 1'b0);
    chk("st_load_count", int'(count), 1);
    stop = 1'b1; cyc(1); stop = 1'b0;
    chk("st_expire", int'(expire), 0);
    chk("st_busy", int'(busy), 0);
    chk("st_count", int'(count), 0);

    // restart together with a tick: tick not counted
    pulse_start(8'd2, 1'b0, 1'b0);
    pulse_start(8'd4, 1'b0, 1'b1);
    chk("rs_count", int'(count), 4);
    chk("rs_busy", int'(busy), 1);
    chk("rs_expire", int'(expire), 0);
    // restart with period 0 acts as stop
    pulse_start(8'd0, 1'b0, 1'b0);
    chk("rs0_busy", int'(busy), 0);
    chk("rs0_count", int'(count), 0);
    // period 0 in idle ignored
    pulse_start(8'd0, 1'b1, 1'b0);
    chk("z_busy", int'(busy), 0);
    chk("z_count", int'(count), 0);
    chk("z_expire", int'(expire), 0);

    // tick held high two clocks
    pulse_start(8'd5, 1'b0, 1'b0);
    cyc(1);
    chk("te_count1", int'(count), 4);
    chk("te_err1", int'(tick_err), 0);
    cyc(1);
    chk("te_count2", int'(count), 3);
    chk("te_err2", int'(tick_err), 1);
    repeat (3) cyc(0);
    chk("te_sticky", int'(tick_err), 1);
    // accepted start colliding with a second consecutive tick: set wins
    cyc(1);
    pulse_start(8'd5, 1'b0, 1'b1);
    chk("te_setwins_err", int'(tick_err), 1);
    chk("te_setwins_count", int'(count), 5);
    pulse_start(8'd5, 1'b0, 1'b0);
    chk("te_clear", int'(tick_err), 0);
    chk("te_clear_count", int'(count), 5);

    // reset in RUN with period 200
    pulse_start(8'd200, 1'b1, 1'b0);
    run_ticks(20, nexp);
    chk("rr_count_pre", int'(count), 196);
    reset = 1'b1; cyc(0);
    chk("rr_busy", int'(busy), 0);
    chk("rr_count", int'(count), 0);
    chk("rr_expire", int'(expire), 0);
    reset = 1'b0;
    // reset on the terminal tick suppresses the expire
    pulse_start(8'd1, 1'b0, 1'b0);
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk("rr_term_expire", int'(expire), 0);
    chk("rr_term_busy", int'(busy), 0);

    // max period auto-reload: first expire after 255 ticks = 1275 clocks
    pulse_start(8'd255, 1'b1, 1'b0);
    chk("mx_load_count", int'(count), 255);
    nexp = 0;
    for (int k = 1; k <= 255; k++) begin
      for (int j = 0; j < 4; j++) begin cyc(0); if (expire) nexp++; end
      cyc(1);
      if (k < 255 && expire) nexp++;
    end
    chk("mx_no_early", nexp, 0);
    chk("mx_expire", int'(expire), 1);
    chk("mx_reload", int'(count), 255);
    chk("mx_busy", int'(busy), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
